// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-client MEM port arbiter.
// Holds the default word/address widths (matching MEM), the client index
// type and the read/write op encoding used on the weN inputs.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_DEF    = 8;
    localparam int unsigned LEN_POW_DEF = 3;

    // Client index: 0 = client 0, 1 = client 1.
    typedef logic client_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester arbiter with a one-bit round-robin pointer.
// Config macro: MEM_ARB_FIXED_PRIORITY_EN (defined: requester 0 always wins,
// no pointer register).
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req       one bit per requester
//   block     suppresses the grant this cycle (pointer then holds)
//   cand      one-hot winner before blocking
//   gnt       one-hot final grant (cand masked by block)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] cand,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Requester 0 wins any contention.
    always_comb begin
        cand = 2'b00;
        if (req[0]) begin
            cand = 2'b01;
        end else if (req[1]) begin
            cand = 2'b10;
        end
    end
`else
    // ptr = index of the requester preferred on the next contention.
    logic ptr;

    always_comb begin
        cand = req;
        if (req == 2'b11) begin
            cand = ptr ? 2'b10 : 2'b01;
        end
    end

    // After any grant the other requester becomes preferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end
`endif

    assign gnt = cand & {2{~block}};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares MEM's single write port and single read port between two clients.
// A write and a read may issue in the same cycle; a read that targets the
// address being written that cycle is held off one cycle so it returns the
// new data. Read data comes back one cycle after the grant with rvalidN.
// Config macro: MEM_ARB_FIXED_PRIORITY_EN (client 0 always wins contention).
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   req/we/addr/wdata 0,1   client requests (we: 1 = write, 0 = read)
//   gnt0, gnt1              combinational grants
//   rvalid0, rvalid1        registered read-return strobes
//   rdata                   read data bus (MEM read word passed through)
//   mem_ena, mem_w_addr, mem_w_word, mem_r_addr, mem_r_word   MEM interface
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD    = WORD_DEF,
    parameter int unsigned LEN_POW = LEN_POW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [LEN_POW-1:0] addr0,
    input  logic [LEN_POW-1:0] addr1,
    input  logic [WORD-1:0]    wdata0,
    input  logic [WORD-1:0]    wdata1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [WORD-1:0]    rdata,
    output logic               mem_ena,
    output logic [LEN_POW-1:0] mem_w_addr,
    output logic [WORD-1:0]    mem_w_word,
    output logic [LEN_POW-1:0] mem_r_addr,
    input  logic [WORD-1:0]    mem_r_word
);

    logic [1:0]         w_req, r_req;
    logic [1:0]         w_cand, w_gnt, r_cand, r_gnt;
    client_t            w_win, r_win;
    logic [LEN_POW-1:0] w_addr_sel, r_addr_sel;
    logic [WORD-1:0]    w_word_sel;
    logic [LEN_POW-1:0] w_addr_q, r_addr_q;
    logic [WORD-1:0]    w_word_q;
    logic               hazard;

    // Split requests by op; nothing is requested while in reset.
    always_comb begin
        w_req = 2'b00;
        r_req = 2'b00;
        if (!rst) begin
            w_req = {req1 && (we1 == OP_WRITE), req0 && (we0 == OP_WRITE)};
            r_req = {req1 && (we1 == OP_READ),  req0 && (we0 == OP_READ)};
        end
    end

    rr_arb2 u_w_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_req),
        .block (1'b0),
        .cand  (w_cand),
        .gnt   (w_gnt)
    );

    rr_arb2 u_r_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (r_req),
        .block (hazard),
        .cand  (r_cand),
        .gnt   (r_gnt)
    );

    // Winner muxes for both ports.
    always_comb begin
        w_win      = client_t'(w_cand[1]);
        r_win      = client_t'(r_cand[1]);
        w_addr_sel = (w_win == 1'b1) ? addr1  : addr0;
        w_word_sel = (w_win == 1'b1) ? wdata1 : wdata0;
        r_addr_sel = (r_win == 1'b1) ? addr1  : addr0;
    end

    // Same-address read and write in one cycle: the read waits a cycle.
    assign hazard = (|w_gnt) && (|r_cand) && (r_addr_sel == w_addr_sel);

    assign gnt0    = w_gnt[0] | r_gnt[0];
    assign gnt1    = w_gnt[1] | r_gnt[1];
    assign mem_ena = |w_gnt;

    // MEM addresses follow the winner and otherwise hold their last value.
    assign mem_w_addr = (|w_gnt) ? w_addr_sel : w_addr_q;
    assign mem_w_word = (|w_gnt) ? w_word_sel : w_word_q;
    assign mem_r_addr = (|r_gnt) ? r_addr_sel : r_addr_q;
    assign rdata      = mem_r_word;

    // Held MEM drive values and the one-cycle read-return strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr_q <= '0;
            w_word_q <= '0;
            r_addr_q <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            rvalid0 <= r_gnt[0];
            rvalid1 <= r_gnt[1];
            if (|w_gnt) begin
                w_addr_q <= w_addr_sel;
                w_word_q <= w_word_sel;
            end
            if (|r_gnt) begin
                r_addr_q <= r_addr_sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized two-client traffic, checked every cycle against a behavioural
// model of the arbitration rules and a reference copy of MEM.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned W = WORD_DEF;
    localparam int unsigned L = LEN_POW_DEF;
    localparam int unsigned D = 1 << L;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, we0, we1;
    logic [L-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1, mem_ena;
    logic [W-1:0] rdata, mem_w_word, mem_r_word;
    logic [L-1:0] mem_w_addr, mem_r_addr;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD(W), .LEN_POW(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .mem_ena    (mem_ena),
        .mem_w_addr (mem_w_addr),
        .mem_w_word (mem_w_word),
        .mem_r_addr (mem_r_addr),
        .mem_r_word (mem_r_word)
    );

    // MEM: one write port, one registered read port.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (mem_ena) mem[mem_w_addr] <= mem_w_word;
        mem_r_word <= mem[mem_r_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [W-1:0] ref_mem [D];
    int           pref_w = 0;
    int           pref_r = 0;
    bit           ret_v  = 1'b0;
    int           ret_c  = 0;
    logic [W-1:0] ret_d  = '0;
    bit           acc0   = 1'b0;
    bit           acc1   = 1'b0;

    function automatic int pick(input bit a, input bit b, input int pref);
        if (a && b) return pref;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    function automatic logic [L-1:0] addr_of(input int c);
        return (c == 0) ? addr0 : addr1;
    endfunction

    function automatic logic [W-1:0] data_of(input int c);
        return (c == 0) ? wdata0 : wdata1;
    endfunction

    always @(negedge clk) begin : model_cmp
        int ww;
        int rw;
        if (rst) begin
            chk("rst_gnt0",       32'(gnt0),       32'd0);
            chk("rst_gnt1",       32'(gnt1),       32'd0);
            chk("rst_rvalid0",    32'(rvalid0),    32'd0);
            chk("rst_rvalid1",    32'(rvalid1),    32'd0);
            chk("rst_mem_ena",    32'(mem_ena),    32'd0);
            chk("rst_mem_w_addr", 32'(mem_w_addr), 32'd0);
            chk("rst_mem_w_word", 32'(mem_w_word), 32'd0);
            chk("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
            pref_w = 0;
            pref_r = 0;
            ret_v  = 1'b0;
            acc0   = 1'b0;
            acc1   = 1'b0;
        end else begin
            chk("rvalid0", 32'(rvalid0), 32'(ret_v && ret_c == 0));
            chk("rvalid1", 32'(rvalid1), 32'(ret_v && ret_c == 1));
            if (ret_v) chk("rdata", 32'(rdata), 32'(ret_d));

            ww = pick(req0 && we0, req1 && we1, pref_w);
            rw = pick(req0 && !we0, req1 && !we1, pref_r);
            if (ww >= 0 && rw >= 0 && addr_of(ww) == addr_of(rw)) rw = -1;

            chk("gnt0",    32'(gnt0),    32'(ww == 0 || rw == 0));
            chk("gnt1",    32'(gnt1),    32'(ww == 1 || rw == 1));
            chk("mem_ena", 32'(mem_ena), 32'(ww >= 0));
            if (ww >= 0) begin
                chk("mem_w_addr", 32'(mem_w_addr), 32'(addr_of(ww)));
                chk("mem_w_word", 32'(mem_w_word), 32'(data_of(ww)));
            end
            if (rw >= 0) chk("mem_r_addr", 32'(mem_r_addr), 32'(addr_of(rw)));

            ret_v = (rw >= 0);
            ret_c = rw;
            if (rw >= 0) ret_d = ref_mem[addr_of(rw)];
            if (ww >= 0) ref_mem[addr_of(ww)] = data_of(ww);
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            if (ww >= 0) pref_w = 1 - ww;
            if (rw >= 0) pref_r = 1 - rw;
`endif
            acc0 = (ww == 0) || (rw == 0);
            acc1 = (ww == 1) || (rw == 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        probe();
        rst = 1'b0;
        tick();
    endtask

    bit p0 = 1'b0;
    bit p1 = 1'b0;

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #11 rst = 1'b0;
        tick();

        // 1: client 0 fills MEM with 1..8
        for (int i = 0; i < 8; i++) begin
            req0 = 1'b1; we0 = OP_WRITE; addr0 = L'(i); wdata0 = W'(i + 1);
            probe();
            chk("t1_gnt0",    32'(gnt0),    32'd1);
            chk("t1_mem_ena", 32'(mem_ena), 32'd1);
            tick();
        end
        req0 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) chk("t1_mem", 32'(mem[i]), 32'(i + 1));

        // 2: contended writes alternate starting with client 0
        do_reset();
        req0 = 1'b1; we0 = OP_WRITE; addr0 = L'(2); wdata0 = 8'hA0;
        req1 = 1'b1; we1 = OP_WRITE; addr1 = L'(3); wdata1 = 8'hB1;
        for (int k = 0; k < 4; k++) begin
            probe();
            chk("t2_gnt0", 32'(gnt0), 32'(k % 2 == 0));
            chk("t2_gnt1", 32'(gnt1), 32'(k % 2 == 1));
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // 3: dual issue, write 4 and read 5
        req0 = 1'b1; we0 = OP_WRITE; addr0 = L'(4); wdata0 = 8'h55;
        req1 = 1'b1; we1 = OP_READ;  addr1 = L'(5);
        probe();
        chk("t3_gnt0", 32'(gnt0), 32'd1);
        chk("t3_gnt1", 32'(gnt1), 32'd1);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        probe();
        chk("t3_rvalid1", 32'(rvalid1), 32'd1);
        chk("t3_rdata",   32'(rdata),   32'h06);
        tick();

        // 4: same-address hazard
        req0 = 1'b1; we0 = OP_WRITE; addr0 = L'(4); wdata0 = 8'h77;
        req1 = 1'b1; we1 = OP_READ;  addr1 = L'(4);
        probe();
        chk("t4_gnt0", 32'(gnt0), 32'd1);
        chk("t4_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0;
        probe();
        chk("t4_gnt1_retry", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        probe();
        chk("t4_rvalid1", 32'(rvalid1), 32'd1);
        chk("t4_rdata",   32'(rdata),   32'h77);
        tick();

        // 5: reset between read grant and return
        req1 = 1'b1; we1 = OP_READ; addr1 = L'(5);
        probe();
        chk("t5_gnt1",       32'(gnt1),       32'd1);
        chk("t5_mem_r_addr", 32'(mem_r_addr), 32'd5);
        rst = 1'b1;
        #1;
        chk("t5_gnt1_rst",    32'(gnt1),       32'd0);
        chk("t5_r_addr_rst",  32'(mem_r_addr), 32'd0);
        chk("t5_w_addr_rst",  32'(mem_w_addr), 32'd0);
        chk("t5_w_word_rst",  32'(mem_w_word), 32'd0);
        chk("t5_mem_ena_rst", 32'(mem_ena),    32'd0);
        req1 = 1'b0;
        tick();
        probe();
        chk("t5_rvalid1", 32'(rvalid1), 32'd0);
        rst = 1'b0;
        tick();
        req0 = 1'b1; we0 = OP_WRITE; addr0 = L'(6); wdata0 = 8'h66;
        req1 = 1'b1; we1 = OP_WRITE; addr1 = L'(7); wdata1 = 8'h99;
        probe();
        chk("t5_pref_gnt0", 32'(gnt0), 32'd1);
        chk("t5_pref_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0;
        probe();
        chk("t5_gnt1_next", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        tick();

        // 6: continuous contended reads
        req0 = 1'b1; we0 = OP_READ; addr0 = L'(0);
        req1 = 1'b1; we1 = OP_READ; addr1 = L'(1);
        for (int k = 0; k < 4; k++) begin
            probe();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            chk("t6_gnt0", 32'(gnt0), 32'd1);
            chk("t6_gnt1", 32'(gnt1), 32'd0);
`else
            chk("t6_gnt0", 32'(gnt0), 32'(k % 2 == 0));
            chk("t6_gnt1", 32'(gnt1), 32'(k % 2 == 1));
`endif
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Random traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            if (!p0) begin
                we0 = 1'($urandom_range(0, 1));
                addr0 = L'($urandom_range(0, D - 1));
                wdata0 = W'($urandom);
                p0 = ($urandom_range(0, 9) < 7);
            end
            if (!p1) begin
                we1 = 1'($urandom_range(0, 1));
                addr1 = L'($urandom_range(0, D - 1));
                wdata1 = W'($urandom);
                p1 = ($urandom_range(0, 9) < 7);
            end
            req0 = p0;
            req1 = p1;
            if (c % 700 == 699) rst = 1'b1;
            tick();
            rst = 1'b0;
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-clock dual-port MEM (one write port, one read port) between two clients, client 0 and client 1.
- Every cycle it grants the write port to at most one client and the read port to at most one client; a write and a read can issue together.
- Returns read data to the requesting client with a registered valid.
- Sits between the clients and MEM and drives all of MEM's address, data and enable inputs.

Parameters:
- WORD, 8, data width; must match MEM's word width.
- LEN_POW, 3, address width; MEM depth is 2**LEN_POW.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  client request; held until granted
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0, addr1  in  LEN_POW  client address
- wdata0, wdata1  in  WORD  client write data
- gnt0, gnt1  out  1  combinational grant; the op is accepted on the edge where reqN and gntN are both 1
- rvalid0, rvalid1  out  1  registered; rdata holds that client's read data this cycle
- rdata  out  WORD  shared read-data bus; passes mem_r_word through
- mem_ena  out  1  MEM enable; 1 only in cycles with a granted write
- mem_w_addr  out  LEN_POW  MEM write address
- mem_w_word  out  WORD  MEM write data
- mem_r_addr  out  LEN_POW  MEM read address
- mem_r_word  in  WORD  MEM registered read data (one-cycle latency)

Behaviour:
- Reset (async, rst = 1):
  - gnt0/gnt1 = 0, rvalid0/rvalid1 = 0, mem_ena = 0, mem addresses and write data = 0.
  - Round-robin pointers rr_w = rr_r = 0, meaning client 0 is preferred next.
- Classification: a write request is reqN & weN; a read request is reqN & ~weN. Each client holds at most one request per cycle.
- Write arbitration, combinational:
  - Only one client requesting a write: that client is granted.
  - Both requesting: grant the client rr_w points to.
  - On any write grant, rr_w moves to the other client on the next edge. With no write grant, rr_w holds.
- Read arbitration: identical rule, using rr_r.
- Dual issue: a write grant and a read grant in the same cycle are legal, e.g. client 0 writes while client 1 reads.
- Hazard: if the granted read address equals the granted write address in the same cycle, the read grant is withheld for that cycle.
  - rr_r does not advance.
  - The read re-arbitrates next cycle, so it always sees the new data.
- MEM drive:
  - mem_ena = any write grant.
  - mem_w_addr / mem_w_word are muxed from the write winner.
  - mem_r_addr is muxed from the read winner; otherwise it holds its last value.
- Read return:
  - Latency 1. rvalidN is registered to 1 on the edge after client N's read grant, for exactly one cycle.
  - rdata = mem_r_word during that cycle.
  - rvalid0 and rvalid1 are mutually exclusive.
- Back-to-back: a client may issue a new request every cycle; reads return in grant order.
- Reset mid-operation: a pending rvalid is dropped, no MEM write is issued while rst = 1, and the pointers return to 0.
- Requests with reqN = 0 have no effect, whatever the weN, addrN and wdataN values.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: client 0 always wins contention on both ports, and rr_w/rr_r are not implemented. The hazard rule is unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Shared package holds:
  - WORD and LEN_POW defaults, consistent with MEM's width/depth constants
  - client index type (1 bit)
  - op encoding constants OP_READ = 0 and OP_WRITE = 1
- One natural sub-module, rr_arb2: the two-requester round-robin arbiter with its pointer register. It is instantiated twice, once for the write port and once for the read port. Under MEM_ARB_FIXED_PRIORITY_EN it reduces to fixed priority.

Test Plan:
1. Reset 10 ns high, then client 0 writes 0x01..0x08 to addresses 0..7, one per cycle. Expect gnt0 = 1 every cycle, mem_ena = 1, and MEM contents 1..8.
2. Both clients write every cycle, client 0 to address 2 with 0xA0 and client 1 to address 3 with 0xB1. Expect grants to alternate 0,1,0,1 starting with client 0, and neither client waits more than 1 cycle.
3. Client 0 writes 0x55 to address 4 while client 1 reads address 5, which holds 6. Expect both granted in the same cycle; next cycle rvalid1 = 1 with rdata = 6.
4. Client 0 writes 0x77 to address 4 while client 1 reads address 4 in the same cycle. Expect the read withheld one cycle, then granted; rvalid1 follows with rdata = 0x77.
5. Client 1 read granted, then rst asserted before the next edge. Expect rvalid1 to stay 0, all outputs to go to 0 immediately, and client 0 to be preferred after release.
6. With MEM_ARB_FIXED_PRIORITY_EN defined and both clients continuously requesting reads, expect gnt0 = 1 and gnt1 = 0 every cycle.
